mc_ctrl: RTL and testbench
==========================

Name: mc_ctrl

Overview:
- Moore control FSM for the multicycle MIPS datapath.
- Sequences the instruction through fetch, decode, execute, memory and writeback; one instruction takes 3–5 states plus memory wait cycles.
- Drives every datapath select and enable: the IorD memory-address mux select, the ALU source muxes, the PC source mux, and the register/memory write enables.
- Stalls on a memory-ready handshake.

Parameters:
- OP_W, 6, opcode field width (instr[31:26]).
- ST_W, 4, state register width.

Ports:
- clk  in  1  system clock. Single clock domain; all state changes on the rising edge.
- rst  in  1  synchronous reset, active-high.
- op  in  OP_W  opcode from the instruction register.
- mem_ready  in  1  memory has completed the current read or write this cycle.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  instruction register load enable.
- RegDst  out  1  register write address select: 0 = rt, 1 = rd.
- MemtoReg  out  1  register write data select: 0 = ALUOut, 1 = MDR.
- RegWrite  out  1  register file write enable.
- ALUSrcA  out  1  ALU A input: 0 = PC, 1 = register A.
- ALUSrcB  out  2  ALU B input: 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2.
- ALUOp  out  2  ALU operation: 00 = add, 01 = sub, 10 = decode funct field.
- PCSrc  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- PCWrite  out  1  unconditional PC write.
- PCWriteCond  out  1  PC write qualified by the ALU Zero flag (datapath combines it).
- bad_op  out  1  one-cycle pulse when an unsupported opcode is decoded.
- state  out  ST_W  current state, for debug.

Behaviour:
- Outputs are decoded combinationally from the state register only (Moore), with one exception: PCWrite and IRWrite in FETCH are additionally ANDed with mem_ready.
- Any output not listed for a state is 0.
- Reset: state = FETCH (0) on the next edge; bad_op = 0.
- While in FETCH after reset: IorD=0, MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00, IRWrite=PCWrite=mem_ready. All other outputs are 0.
- States, outputs and transitions:
  - FETCH(0): outputs as above. Stay while mem_ready=0; go to DECODE when mem_ready=1.
  - DECODE(1): ALUSrcA=0, ALUSrcB=11, ALUOp=00 (precomputes the branch target). Next state by op:
    - lw 100011 or sw 101011 → MEMADR
    - R-type 000000 → REXEC
    - beq 000100 → BEQ
    - addi 001000 → AEXEC
    - j 000010 → JUMP
    - any other opcode → FETCH, with bad_op=1 registered for exactly one cycle.
  - MEMADR(2): ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to MEMRD for lw, MEMWR for sw.
  - MEMRD(3): IorD=1, MemRead=1. Hold until mem_ready=1, then go to MEMWB.
  - MEMWB(4): RegDst=0, MemtoReg=1, RegWrite=1. Go to FETCH.
  - MEMWR(5): IorD=1, MemWrite=1. Hold until mem_ready=1, then go to FETCH.
  - REXEC(6): ALUSrcA=1, ALUSrcB=00, ALUOp=10. Go to RWB.
  - RWB(7): RegDst=1, MemtoReg=0, RegWrite=1. Go to FETCH.
  - BEQ(8): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, PCWriteCond=1. Go to FETCH.
  - AEXEC(9): ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to AWB.
  - AWB(10): RegDst=0, MemtoReg=0, RegWrite=1. Go to FETCH.
  - JUMP(11): PCSrc=10, PCWrite=1. Go to FETCH.
  - Unused encodings 12–15: go to FETCH next cycle; all outputs 0.
- mem_ready is sampled only in FETCH, MEMRD and MEMWR; it is ignored elsewhere.
- Reset takes priority over every transition. Asserting rst in any state, including mid memory wait, returns to FETCH on that edge with no write enable asserted the following cycle.
- op is sampled only in DECODE and MEMADR. It is assumed stable because IRWrite is low outside FETCH.
- Latency, with no wait states:
  - lw 5 cycles; sw 4; R-type 4; addi 4; beq 3; j 3.
  - Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.

Optional Feature:
- Macro: MC_CTRL_BNE_EN.
- Defined: op 000101 (bne) goes from DECODE to state BNE(12).
  - Outputs identical to BEQ, except PCWriteCond is replaced by PCWriteCondN, an additional 1-bit output meaning PC write when Zero=0.
  - BNE returns to FETCH. State 12 is legal.
- Undefined: 000101 is an illegal opcode (bad_op pulse, return to FETCH); port PCWriteCondN is absent.

Test Plan:
- Reset: hold rst=1 for 2 cycles with mem_ready=1 → state=0, MemRead=1, IorD=0, ALUSrcB=01, IRWrite=PCWrite=1, RegWrite=MemWrite=0, bad_op=0.
- lw (op=100011), mem_ready always 1 → states 0,1,2,3,4,0. IorD=1 only in state 3. RegWrite=1 with MemtoReg=1 only in state 4. Total 5 cycles.
- sw with mem_ready=0 for 3 cycles in MEMWR → MemWrite=1 and IorD=1 held for 4 cycles, then FETCH. RegWrite is never asserted.
- Fetch stall: mem_ready=0 for 2 cycles in FETCH → IRWrite=PCWrite=0 during the stall, MemRead=1 throughout; IRWrite=PCWrite=1 in the cycle mem_ready rises.
- Control flow:
  - beq → state 8 with ALUOp=01, PCSrc=01, PCWriteCond=1, then FETCH.
  - j → state 11 with PCSrc=10, PCWrite=1.
  - op=111111 → bad_op=1 for exactly one cycle, then FETCH.
- rst=1 asserted in MEMRD while mem_ready=0 → next cycle state=0, RegWrite=0. bne (000101) pulses bad_op unless MC_CTRL_BNE_EN is defined, in which case it reaches state 12 with PCWriteCondN=1.

Source files
------------

// File: rtl/mc_ctrl.sv
// mc_ctrl: Moore control FSM for the multicycle MIPS datapath.
// Sequences fetch/decode/execute/memory/writeback and drives all datapath
// selects and enables. Stalls in FETCH, MEMRD and MEMWR until mem_ready.
// Optional feature macro: MC_CTRL_BNE_EN adds bne (op 000101) via state BNE(12)
// and the PCWriteCondN output; without it 000101 is an illegal opcode.
module mc_ctrl #(
   parameter int unsigned OP_W = 6,
   parameter int unsigned ST_W = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [OP_W-1:0] op,
   input  logic            mem_ready,
   output logic            IorD,
   output logic            MemRead,
   output logic            MemWrite,
   output logic            IRWrite,
   output logic            RegDst,
   output logic            MemtoReg,
   output logic            RegWrite,
   output logic            ALUSrcA,
   output logic [1:0]      ALUSrcB,
   output logic [1:0]      ALUOp,
   output logic [1:0]      PCSrc,
   output logic            PCWrite,
   output logic            PCWriteCond,
`ifdef MC_CTRL_BNE_EN
   output logic            PCWriteCondN,
`endif
   output logic            bad_op,
   output logic [ST_W-1:0] state
);

   localparam logic [ST_W-1:0] S_FETCH  = ST_W'(0);
   localparam logic [ST_W-1:0] S_DECODE = ST_W'(1);
   localparam logic [ST_W-1:0] S_MEMADR = ST_W'(2);
   localparam logic [ST_W-1:0] S_MEMRD  = ST_W'(3);
   localparam logic [ST_W-1:0] S_MEMWB  = ST_W'(4);
   localparam logic [ST_W-1:0] S_MEMWR  = ST_W'(5);
   localparam logic [ST_W-1:0] S_REXEC  = ST_W'(6);
   localparam logic [ST_W-1:0] S_RWB    = ST_W'(7);
   localparam logic [ST_W-1:0] S_BEQ    = ST_W'(8);
   localparam logic [ST_W-1:0] S_AEXEC  = ST_W'(9);
   localparam logic [ST_W-1:0] S_AWB    = ST_W'(10);
   localparam logic [ST_W-1:0] S_JUMP   = ST_W'(11);
`ifdef MC_CTRL_BNE_EN
   localparam logic [ST_W-1:0] S_BNE    = ST_W'(12);
`endif

   localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
   localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);
   localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
`ifdef MC_CTRL_BNE_EN
   localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6'b000101);
`endif
   localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
   localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
   localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);

   logic [ST_W-1:0] state_q, state_d;
   logic            bad_op_q, bad_op_d;

   // State register and registered illegal-opcode pulse; reset wins over all.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_FETCH;
         bad_op_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         bad_op_q <= bad_op_d;
      end
   end

   // Next-state logic; mem_ready only matters in FETCH/MEMRD/MEMWR, op only in DECODE/MEMADR.
   always_comb begin
      state_d  = S_FETCH;
      bad_op_d = 1'b0;
      case (state_q)
         S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_REXEC;
               OP_BEQ:       state_d = S_BEQ;
               OP_ADDI:      state_d = S_AEXEC;
               OP_J:         state_d = S_JUMP;
`ifdef MC_CTRL_BNE_EN
               OP_BNE:       state_d = S_BNE;
`endif
               default: begin
                  state_d  = S_FETCH;
                  bad_op_d = 1'b1;
               end
            endcase
         end
         S_MEMADR: state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
         S_REXEC:  state_d = S_RWB;
         S_AEXEC:  state_d = S_AWB;
         default:  state_d = S_FETCH;
      endcase
   end

   // Moore output decode from the state register; FETCH gates IRWrite/PCWrite with mem_ready.
   always_comb begin
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      RegDst      = 1'b0;
      MemtoReg    = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      ALUOp       = 2'b00;
      PCSrc       = 2'b00;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
`ifdef MC_CTRL_BNE_EN
      PCWriteCondN = 1'b0;
`endif
      case (state_q)
         S_FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = 2'b01;
            IRWrite = mem_ready;
            PCWrite = mem_ready;
         end
         S_DECODE: ALUSrcB = 2'b11;
         S_MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         S_MEMRD: begin
            IorD    = 1'b1;
            MemRead = 1'b1;
         end
         S_MEMWB: begin
            MemtoReg = 1'b1;
            RegWrite = 1'b1;
         end
         S_MEMWR: begin
            IorD     = 1'b1;
            MemWrite = 1'b1;
         end
         S_REXEC: begin
            ALUSrcA = 1'b1;
            ALUOp   = 2'b10;
         end
         S_RWB: begin
            RegDst   = 1'b1;
            RegWrite = 1'b1;
         end
         S_BEQ: begin
            ALUSrcA     = 1'b1;
            ALUOp       = 2'b01;
            PCSrc       = 2'b01;
            PCWriteCond = 1'b1;
         end
         S_AEXEC: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         S_AWB:  RegWrite = 1'b1;
         S_JUMP: begin
            PCSrc   = 2'b10;
            PCWrite = 1'b1;
         end
`ifdef MC_CTRL_BNE_EN
         S_BNE: begin
            ALUSrcA      = 1'b1;
            ALUOp        = 2'b01;
            PCSrc        = 2'b01;
            PCWriteCondN = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   assign state  = state_q;
   assign bad_op = bad_op_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: scoreboard bench for mc_ctrl. A driver walks each instruction
// through its expected state sequence, pushing the expected per-cycle outputs;
// a monitor pops one entry per cycle on the falling edge and compares.
module tb_mc_ctrl;

   localparam int unsigned CTL_W = 18;

   localparam int F  = 0, D  = 1, MA = 2, MR = 3, WB = 4, MW = 5;
   localparam int RX = 6, RW = 7, BQ = 8, AX = 9, AW = 10, JP = 11, BN = 12;

   typedef struct {
      int               st;
      logic [CTL_W-1:0] ctl;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] op;
   logic       mem_ready;
   logic       IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite;
   logic       ALUSrcA, PCWrite, PCWriteCond, bad_op;
   logic [1:0] ALUSrcB, ALUOp, PCSrc;
   logic [3:0] state;
   logic       pcwn;

   exp_t       sbq[$];
   int         n_cmp = 0;
   int         n_mis = 0;
   int         cyc   = 0;
   logic [5:0] cur_op = 6'd0;
   logic       bad_pend = 1'b0;

   mc_ctrl #(.OP_W(6), .ST_W(4)) dut (
      .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
      .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
`ifdef MC_CTRL_BNE_EN
      .PCWriteCondN(pcwn),
`endif
      .bad_op(bad_op), .state(state)
   );

`ifndef MC_CTRL_BNE_EN
   assign pcwn = 1'b0;
`endif

   always #5 clk = ~clk;

   // Reference: control word each state must present, straight from the state table.
   function automatic logic [CTL_W-1:0] model(input int st, input logic mr, input logic bad);
      logic iord, mrd, mw, irw, rdst, mtr, rw, srca, pcw, pwc, pwcn;
      logic [1:0] srcb, aluop, pcsrc;
      {iord, mrd, mw, irw, rdst, mtr, rw, srca, pcw, pwc, pwcn} = '0;
      srcb = 2'b00; aluop = 2'b00; pcsrc = 2'b00;
      case (st)
         F:  begin mrd = 1; srcb = 2'b01; irw = mr; pcw = mr; end
         D:  srcb = 2'b11;
         MA: begin srca = 1; srcb = 2'b10; end
         MR: begin iord = 1; mrd = 1; end
         WB: begin mtr = 1; rw = 1; end
         MW: begin iord = 1; mw = 1; end
         RX: begin srca = 1; aluop = 2'b10; end
         RW: begin rdst = 1; rw = 1; end
         BQ: begin srca = 1; aluop = 2'b01; pcsrc = 2'b01; pwc = 1; end
         AX: begin srca = 1; srcb = 2'b10; end
         AW: rw = 1;
         JP: begin pcsrc = 2'b10; pcw = 1; end
         BN: begin srca = 1; aluop = 2'b01; pcsrc = 2'b01; pwcn = 1; end
         default: ;
      endcase
      return {iord, mrd, mw, irw, rdst, mtr, rw, srca, srcb, aluop, pcsrc, pcw, pwc, pwcn, bad};
   endfunction

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   // One cycle: drive inputs just after the edge and record what the DUT must show.
   task automatic step(input int st, input logic mr, input logic r);
      exp_t e;
      @(posedge clk);
      #1;
      rst       = r;
      mem_ready = mr;
      op        = cur_op;
      e.st      = st;
      e.ctl     = model(st, mr, bad_pend);
      bad_pend  = 1'b0;
      sbq.push_back(e);
   endtask

   // Walk one instruction through fetch stalls, decode and its execution path.
   task automatic run_instr(input logic [5:0] o, input int fs, input int ms, input bit rst_memrd);
      cur_op = o;
      repeat (fs) step(F, 1'b0, 1'b0);
      step(F, 1'b1, 1'b0);
      step(D, rb(), 1'b0);
      case (o)
         6'b100011: begin
            step(MA, rb(), 1'b0);
            if (rst_memrd) begin
               step(MR, 1'b0, 1'b1);
            end else begin
               repeat (ms) step(MR, 1'b0, 1'b0);
               step(MR, 1'b1, 1'b0);
               step(WB, rb(), 1'b0);
            end
         end
         6'b101011: begin
            step(MA, rb(), 1'b0);
            repeat (ms) step(MW, 1'b0, 1'b0);
            step(MW, 1'b1, 1'b0);
         end
         6'b000000: begin step(RX, rb(), 1'b0); step(RW, rb(), 1'b0); end
         6'b000100: step(BQ, rb(), 1'b0);
         6'b001000: begin step(AX, rb(), 1'b0); step(AW, rb(), 1'b0); end
         6'b000010: step(JP, rb(), 1'b0);
`ifdef MC_CTRL_BNE_EN
         6'b000101: step(BN, rb(), 1'b0);
`endif
         default: bad_pend = 1'b1;
      endcase
   endtask

   // Monitor: one expected entry per cycle, compared mid-cycle.
   initial begin
      exp_t             e;
      logic [CTL_W-1:0] act;
      forever begin
         @(negedge clk);
         cyc++;
         if (sbq.size() != 0) begin
            e   = sbq.pop_front();
            act = {IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                   ALUSrcB, ALUOp, PCSrc, PCWrite, PCWriteCond, pcwn, bad_op};
            n_cmp++;
            if (state !== 4'(e.st) || act !== e.ctl) begin
               n_mis++;
               $display("FAIL cycle %0d ctrl: got state=%0d ctl=%b, expected state=%0d ctl=%b",
                        cyc, state, act, e.st, e.ctl);
            end
         end
      end
   end

   // Stimulus: directed test-plan cases, then randomized instruction stream.
   initial begin
      logic [5:0] ops [8];
      logic [5:0] o;
      ops[0] = 6'b100011; ops[1] = 6'b101011; ops[2] = 6'b000000; ops[3] = 6'b000100;
      ops[4] = 6'b001000; ops[5] = 6'b000010; ops[6] = 6'b000101; ops[7] = 6'b111111;
      rst = 1'b1; mem_ready = 1'b1; op = 6'd0;
      step(F, 1'b1, 1'b1);
      run_instr(6'b100011, 0, 0, 1'b0);
      run_instr(6'b101011, 0, 3, 1'b0);
      run_instr(6'b000000, 2, 0, 1'b0);
      run_instr(6'b000100, 0, 0, 1'b0);
      run_instr(6'b000010, 0, 0, 1'b0);
      run_instr(6'b111111, 0, 0, 1'b0);
      run_instr(6'b001000, 0, 0, 1'b0);
      run_instr(6'b100011, 1, 2, 1'b1);
      run_instr(6'b000101, 0, 0, 1'b0);
      run_instr(6'b000100, 0, 0, 1'b0);
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 4) == 0) o = 6'($urandom);
         else o = ops[$urandom_range(0, 7)];
         run_instr(o, $urandom_range(0, 3), $urandom_range(0, 3), ($urandom_range(0, 15) == 0));
      end
      repeat (3) @(posedge clk);
      n_cmp++;
      if (sbq.size() != 0) begin
         n_mis++;
         $display("FAIL drain: got %0d unchecked entries, expected 0", sbq.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
